// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   Receives 8N1 UART frames, LSB first, and presents each correctly framed
//   byte on rx_data. A byte is announced by a level change of rx_strobe.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (4..65535), default 868
//
// Ports
//   clk            system clock, all state on its rising edge
//   rst            asynchronous active-high reset
//   rx_serial      raw UART line (idle high), not synchronous to clk
//   rx_data        last correctly framed byte, held until the next one
//   rx_strobe      toggles once per received byte
//   framing_error  one-cycle pulse when a stop bit samples low
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       framing_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Terminal counts for the half-bit (start) and full-bit sample intervals.
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  logic        sync1_q, sync2_q;
  logic [1:0]  vld_q, vld_d;
  logic        armed_q, armed_d;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        strobe_q, strobe_d;
  logic        fe_q, fe_d;
  logic        rxs;

  assign rxs = sync2_q;

  always_comb begin
    // vld_q[1] marks that sync2_q holds a real line sample rather than the
    // reset value; armed_q records that the line has been seen idle-high,
    // so a line already low at reset release is not mistaken for a start.
    vld_d    = {vld_q[0], 1'b1};
    armed_d  = armed_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    fe_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (vld_q[1]) begin
          if (rxs) begin
            armed_d = 1'b1;
          end else if (!armed_q) begin
            state_d = BREAK;
          end else begin
            state_d = START;
            cnt_d   = 16'd0;
            bit_d   = 3'd0;
          end
        end
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = 16'd0;
          // A high sample mid-start-bit is a glitch: drop it silently.
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = 16'd0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = 16'd0;
          if (rxs) begin
            data_d   = shift_q;
            strobe_d = ~strobe_q;
            state_d  = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BREAK: begin
        // Wait out a held-low line so it cannot start a new frame.
        if (rxs) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      strobe_q <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      sync1_q  <= rx_serial;
      sync2_q  <= sync1_q;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      fe_q     <= fe_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_strobe     = strobe_q;
  assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
//   Directed bench for uart_rx_byte at CLKS_PER_BIT=16. Every frame sent
//   pushes its expected outcome (byte or framing error, plus the edge by
//   which it must appear) onto a queue; a compare process on the falling
//   edge matches each DUT strobe toggle / error pulse against that queue.
module tb_uart_rx_byte;

  localparam int CLKS = 16;
  // Edges from the first cycle rxs is low to the result edge.
  localparam int LAT  = CLKS / 2 + 9 * CLKS;
  // The line is driven just after edge k; rxs first reads low after edge k+2.
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       framing_error;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial     (rx_serial),
    .rx_data       (rx_data),
    .rx_strobe     (rx_strobe),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         err;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   toggles = 0;
  int   fe_count = 0;
  int   toggle_t[$];
  logic       prev_strobe = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_data", rx_data, 8'h00);
      check("rst_strobe", rx_strobe, 0);
      check("rst_fe", framing_error, 0);
      prev_strobe = 1'b0;
      prev_data   = 8'h00;
    end else begin
      if (rx_strobe !== prev_strobe || framing_error === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_fe", framing_error, e.err);
          check("event_kind_toggle", (rx_strobe !== prev_strobe), !e.err);
          check_rng("event_time", cyc, e.t + SYNC + LAT - 1, e.t + SYNC + LAT + 1);
          if (e.err) check("fe_data_held", rx_data, prev_data);
          else       check("rx_byte", rx_data, e.data);
        end
        if (rx_strobe !== prev_strobe) begin
          toggles++;
          toggle_t.push_back(cyc);
        end
        if (framing_error === 1'b1) fe_count++;
      end else if (rx_data !== prev_data) begin
        check("data_without_toggle", rx_data, prev_data);
      end
      if (exp_q.size() != 0 && cyc > exp_q[0].t + SYNC + LAT + 1) begin
        e = exp_q.pop_front();
        $display("FAIL missing_event got none expected %0h by cycle %0d", e.data, e.t + SYNC + LAT + 1);
        checks++;
        errors++;
      end
      prev_strobe = rx_strobe;
      prev_data   = rx_data;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  // Sends one frame starting right now (call just after a rising edge).
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int extra_low);
    exp_t e;
    e.data = b;
    e.err  = !stop_ok;
    e.t    = cyc;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (extra_low > 0) begin
      rx_serial = 1'b0;
      repeat (extra_low) @(posedge clk);
      #1;
    end
    $display("frame %02h stop=%0d at cycle %0d", b, stop_ok, e.t);
  endtask

  initial begin
    logic [7:0] abort_byte;
    int gap;
    abort_byte = 8'h7E;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    // Single byte 'A'.
    send_byte(8'h41, 1'b1, 0);
    idle(4);
    check("A_data", rx_data, 8'h41);
    check("A_strobe", rx_strobe, 1);
    check("A_fe", fe_count, 0);

    // Back-to-back '3' then 'f'.
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h66, 1'b1, 0);
    idle(4);
    check("b2b_data", rx_data, 8'h66);
    check("b2b_toggles", toggles, 3);
    check_rng("b2b_spacing", toggle_t[2] - toggle_t[1], 159, 161);

    // Short glitch on the line.
    rx_serial = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(40);
    check("glitch_toggles", toggles, 3);
    check("glitch_data", rx_data, 8'h66);

    // Framing error with line held low 100 cycles from the stop bit.
    send_byte(8'h55, 1'b0, 100 - CLKS);
    idle(30);
    send_byte(8'h31, 1'b1, 0);
    idle(4);
    check("fe_count", fe_count, 1);
    check("fe_toggles", toggles, 4);
    check("fe_then_data", rx_data, 8'h31);

    // Reset during data bit 4 of 0x7E; this frame must vanish.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rx_serial = abort_byte[4];
    repeat (CLKS / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_data", rx_data, 8'h00);
    check("rst_async_strobe", rx_strobe, 0);
    repeat (4) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    rst = 1'b0;
    idle(20);
    send_byte(8'h39, 1'b1, 0);
    idle(4);
    check("rst_then_data", rx_data, 8'h39);
    check("rst_then_strobe", rx_strobe, 1);
    check("rst_then_toggles", toggles, 5);

    // Sweep every byte value with random idle gaps.
    for (int v = 0; v < 256; v++) begin
      gap = $urandom_range(0, 40);
      if (gap > 0) idle(gap);
      send_byte(v[7:0], 1'b1, 0);
    end
    idle(10);
    check("sweep_toggles", toggles, 5 + 256);
    check("sweep_fe", fe_count, 1);
    check("sweep_last", rx_data, 8'hFF);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
